// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and loader state type, used by the loader
// and by the ControlUnit decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam logic [2:0] KIND_R       = 3'd0;
    localparam logic [2:0] KIND_ADDI    = 3'd1;
    localparam logic [2:0] KIND_LW      = 3'd2;
    localparam logic [2:0] KIND_SW      = 3'd3;
    localparam logic [2:0] KIND_BEQ     = 3'd4;
    localparam logic [2:0] KIND_J       = 3'd5;
    localparam logic [2:0] KIND_HLT     = 3'd6;
    localparam logic [2:0] KIND_ILLEGAL = 3'd7;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LOAD,
        LD_FLUSH,
        LD_DONE,
        LD_ERR
    } ld_state_e;

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational instruction packer: instruction kind plus fields -> 32-bit
// MIPS word, with a legal flag for kinds that have an encoding.
module instr_packer
    import mips_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        legal,
    output logic [31:0] word
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        legal = 1'b1;
        word  = '0;
        case (kind)
            KIND_R:    word = {OP_RTYPE, rs, rt, rd, 5'b0, funct};
            KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
            KIND_LW:   word = {OP_LW, rs, rt, imm};
            KIND_SW:   word = {OP_SW, rs, rt, imm};
            KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
            KIND_J:    word = {OP_J, target};
            KIND_HLT:  word = {OP_HLT, 26'b0};
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction loader: accepts encoded-instruction beats over valid/ready and
// writes them to consecutive imem words from base_addr until HLT.
module instr_encoder_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        legal;
    logic [31:0] word;

    instr_packer u_packer (
        .kind   (in_kind),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .funct  (in_funct),
        .imm    (in_imm),
        .target (in_target),
        .legal  (legal),
        .word   (word)
    );

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (start) begin
                    state_d = LD_LOAD;
                    wptr_d  = base_addr;
                    count_d = '0;
                end
            end
            LD_LOAD: begin
                // A full window rejects every further beat, HLT included.
                if (in_valid) begin
                    if (!legal || count_q == DEPTH_C) begin
                        state_d = LD_ERR;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = wptr_q;
                        wdata_d = word;
                        wptr_d  = wptr_q + PTR_ONE;
                        count_d = count_q + CNT_ONE;
                        if (in_kind == KIND_HLT) state_d = LD_FLUSH;
                    end
                end
            end
            LD_FLUSH: state_d = LD_DONE;
            default:  state_d = LD_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LD_IDLE;
            wptr_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready   = (state_q == LD_LOAD);
    assign busy       = (state_q == LD_LOAD) || (state_q == LD_FLUSH);
    assign done       = (state_q == LD_DONE);
    assign err        = (state_q == LD_ERR);
    assign count      = count_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule
